// File: rtl/seq_mult_pkg.sv
// Shared constants for the iterative shift-add multiplier.
// Build option: SEQ_MULT_SIGNED_EN selects two's-complement operands in seq_mult_32.
package seq_mult_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CTR_W  = $clog2(WIDTH) + 1;
    localparam int unsigned IDX_W  = $clog2(WIDTH);
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(WIDTH - 1);
    localparam logic [CTR_W-1:0] CTR_DONE = CTR_W'(WIDTH);

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result signals between the bus wrapper (master) and the multiplier (slave).
interface seq_mult_if;
    import seq_mult_pkg::*;

    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [PROD_W-1:0] p;
    logic              rdy;

    modport master (output a, output b, input p, input rdy);
    modport slave  (input a, input b, output p, output rdy);

endinterface

// File: rtl/seq_mult_ctrl.sv
// Step counter and result-valid flag: loads on reset, counts WIDTH steps, then holds in DONE.
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [CTR_W-1:0] ctr_o,
    output logic             busy_o,
    output logic             rdy_o
);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             rdy_q, rdy_d;
    logic             busy;

    assign busy = (ctr_q != CTR_DONE);

    always_comb begin
        ctr_d = ctr_q;
        rdy_d = rdy_q;
        if (reset) begin
            ctr_d = '0;
            rdy_d = 1'b0;
        end else if (busy) begin
            ctr_d = ctr_q + 1'b1;
            if (ctr_q == CTR_LAST) begin
                rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        ctr_q <= ctr_d;
        rdy_q <= rdy_d;
    end

    assign ctr_o  = ctr_q;
    assign busy_o = busy;
    assign rdy_o  = rdy_q;

endmodule

// File: rtl/seq_mult_32.sv
// Iterative shift-add multiplier, one multiplier bit per clock; reset doubles as load/start.
// Build option: define SEQ_MULT_SIGNED_EN for a signed (two's-complement) product.
module seq_mult_32
    import seq_mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    seq_mult_if.slave   bus
);

    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplr_q, mplr_d;
    logic [PROD_W-1:0] p_q, p_d;
    logic [PROD_W-1:0] mcand_ext;
    logic [PROD_W-1:0] addend;
    logic [CTR_W-1:0]  ctr;
    logic              busy;
    logic              rdy;
    logic              do_sub;

    seq_mult_ctrl u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .ctr_o  (ctr),
        .busy_o (busy),
        .rdy_o  (rdy)
    );

`ifdef SEQ_MULT_SIGNED_EN
    assign mcand_ext = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
    // The multiplier's sign bit carries weight -2^(WIDTH-1), so its partial product is subtracted.
    assign do_sub    = (ctr == CTR_LAST);
`else
    assign mcand_ext = {{WIDTH{1'b0}}, bus.a};
    assign do_sub    = 1'b0;
`endif

    assign addend = mcand_q << ctr;

    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        p_d     = p_q;
        if (reset) begin
            mcand_d = mcand_ext;
            mplr_d  = bus.b;
            p_d     = '0;
        end else if (busy && mplr_q[ctr[IDX_W-1:0]]) begin
            p_d = do_sub ? (p_q - addend) : (p_q + addend);
        end
    end

    always_ff @(posedge clk) begin
        mcand_q <= mcand_d;
        mplr_q  <= mplr_d;
        p_q     <= p_d;
    end

    assign bus.p   = p_q;
    assign bus.rdy = rdy;

endmodule

// File: tb/tb_seq_mult_32.sv
// Scoreboard bench for seq_mult_32: stimulus queues expected products, a monitor checks at rdy.
module tb_seq_mult_32;
    import seq_mult_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seq_mult_if bus ();

    seq_mult_32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic        rdy_prev = 1'b0;

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint unsigned ux;
        longint unsigned uy;
`ifdef SEQ_MULT_SIGNED_EN
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
`else
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = 0;
        sy = 0;
        return 64'(ux * uy) + 64'(sx + sy);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: on each rising rdy, pop the oldest expected product and compare.
    always @(negedge clk) begin
        if (bus.rdy === 1'b1 && rdy_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                check("product", bus.p, exp_q.pop_front());
            end
        end
        rdy_prev <= bus.rdy;
    end

    task automatic load(input logic [31:0] x, input logic [31:0] y, input int cycles);
        bus.a = x;
        bus.b = y;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check("reset_p", bus.p, 64'd0);
        check("reset_rdy", {63'd0, bus.rdy}, 64'd0);
    endtask

    // Releases reset and counts edges until rdy; optionally perturbs a mid-run.
    task automatic run(input logic [31:0] x, input logic [31:0] y, input bit poke_a);
        int got;
        got = -1;
        exp_q.push_back(ref_prod(x, y));
        reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (poke_a && i == 5) bus.a = 32'd9;
            if (bus.rdy === 1'b1) begin
                got = i;
                break;
            end
        end
        check("latency", 64'(got), 64'd32);
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y);
        load(x, y, 2);
        run(x, y, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold_exp;
        bus.a = '0;
        bus.b = '0;

        op(32'd3, 32'd5);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op(32'hFFFF_FFFD, 32'd7);
        op(32'h8000_0000, 32'h8000_0000);
        op(32'd1, 32'h8000_0001);

        load(32'd0, 32'h1234_5678, 2);
        run(32'd0, 32'h1234_5678, 1'b1);

        // Abort mid-run: rdy must stay low, then reload completes normally.
        load(32'd100, 32'd200, 2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("abort_rdy_low", {63'd0, bus.rdy}, 64'd0);
        end
        load(32'd6, 32'd7, 1);
        run(32'd6, 32'd7, 1'b0);

        // DONE hold for 50 cycles, then reset clears on that edge.
        hold_exp = ref_prod(32'd6, 32'd7);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (i % 10 == 0) begin
                check("hold_p", bus.p, hold_exp);
                check("hold_rdy", {63'd0, bus.rdy}, 64'd1);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("done_reset_rdy", {63'd0, bus.rdy}, 64'd0);
        check("done_reset_p", bus.p, 64'd0);

        for (int k = 0; k < 20; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 1) ra = 32'h8000_0000 | ra;
            if (k % 5 == 2) rb = 32'h8000_0000 | rb;
            op(ra, rb);
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
